stencil_unrolled_ctrl: RTL and testbench

- Parametrised loop-nest controller for unrolled 2-D stencil pipelines such as jacobi2d with UNROLL lanes.
- Replaces the flat start/started/done wrapper with a real schedule:
  - walks the input image in UNROLL-wide column groups;
  - issues per-iteration enables and coordinates to the producer op (t1 update) and, after a fixed row-buffer delay, to the stencil update op;
  - reports busy and a completion pulse.
- Sits at the top of each generated app, driving the op and buffer instances.

---
 rtl/stencil_ctrl_pkg.sv | 33 +++
 rtl/loop_nest_counter.sv | 67 ++++++
 rtl/stencil_unrolled_ctrl.sv | 165 ++++++++++++++++
 tb/tb_stencil_unrolled_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stencil_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stencil_ctrl_pkg
// Description : Shared types and helpers for the unrolled stencil loop-nest
//               controller: FSM state encoding, max and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package stencil_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } ctrl_state_t;

    // Larger of two integers, used to size the iteration schedule
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to encode n distinct values (never less than 1)
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold any value in 0..max_val
    function automatic int cnt_width(input int max_val);
        return width_of(max_val + 1);
    endfunction

endpackage : stencil_ctrl_pkg
`default_nettype wire

// File: rtl/loop_nest_counter.sv
`default_nettype none
// ============================================================================
// Module      : loop_nest_counter
// Description : Column/row walker over an image in UNROLL-wide column groups.
//               The column steps by UNROLL and wraps into the next row; the
//               whole walk wraps back to (0,0) after the last group.
// Revision    : 1.0 - initial release
// ============================================================================
module loop_nest_counter
    import stencil_ctrl_pkg::*;
#(
    parameter int UNROLL = 4,
    parameter int IMG_W  = 16,
    parameter int ROWS   = 6,
    parameter int YW     = width_of(ROWS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       adv,
    output logic [width_of(IMG_W)-1:0] x,
    output logic [YW-1:0]              y,
    output logic                       last
);

    localparam int XW = width_of(IMG_W);
    localparam logic [XW-1:0] C_X_LAST = XW'(IMG_W - UNROLL);
    localparam logic [XW-1:0] C_X_STEP = XW'(UNROLL);
    localparam logic [YW-1:0] C_Y_LAST = YW'(ROWS - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Next coordinate: clear wins, otherwise step only when advanced
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (x_q == C_X_LAST) begin
                x_d = '0;
                y_d = (y_q == C_Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + C_X_STEP;
            end
        end
    end

    // Coordinate registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == C_X_LAST) && (y_q == C_Y_LAST);

endmodule : loop_nest_counter
`default_nettype wire

// File: rtl/stencil_unrolled_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stencil_unrolled_ctrl
// Description : Loop-nest controller for unrolled 2-D stencil pipelines.
//               Issues producer (t1) iterations, then stencil-update
//               iterations DELAY iterations later, with stall freezing the
//               whole schedule. Optional busy-cycle counter is built when
//               STENCIL_CTRL_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module stencil_unrolled_ctrl
    import stencil_ctrl_pkg::*;
#(
    parameter int UNROLL = 4,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 6,
    parameter int DELAY  = 2 * (IMG_W / UNROLL) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stall,
    output logic                       busy,
    output logic                       done,
    output logic                       t1_en,
    output logic [width_of(IMG_W)-1:0] t1_x,
    output logic [width_of(IMG_H)-1:0] t1_y,
    output logic                       upd_en,
    output logic [width_of(IMG_W)-1:0] upd_x,
    output logic [width_of(IMG_H)-1:0] upd_y
`ifdef STENCIL_CTRL_PERF_EN
    ,
    output logic [31:0]                perf_cycles
`endif
);

    localparam int C_COLS  = IMG_W / UNROLL;
    localparam int C_N_IN  = C_COLS * IMG_H;
    localparam int C_N_OUT = C_COLS * (IMG_H - 2);
    localparam int C_LAST  = max_of(C_N_IN, DELAY + C_N_OUT) - 1;
    // g must reach LAST+1 on the exit step without wrapping
    localparam int GW      = cnt_width(C_LAST + 1);
    localparam int YW      = width_of(IMG_H);

    localparam logic [GW-1:0] C_G_N_IN    = GW'(C_N_IN);
    localparam logic [GW-1:0] C_G_DELAY   = GW'(DELAY);
    localparam logic [GW-1:0] C_G_UPD_END = GW'(DELAY + C_N_OUT);
    localparam logic [GW-1:0] C_G_LAST    = GW'(C_LAST);

    ctrl_state_t   state_q, state_d;
    logic [GW-1:0] g_q, g_d;
    logic          w_clr;
    logic          w_run;
    logic          w_t1_last;
    logic          w_upd_last;
    logic          w_unused_last;

    // Next state and global iteration counter
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        w_clr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    g_d     = '0;
                    w_clr   = 1'b1;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    g_d = g_q + 1'b1;
                    if (g_q == C_G_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
        end
    end

    // Status decoded straight from the state flop; strobes are gated by stall
    assign w_run  = (state_q == S_RUN);
    assign busy   = w_run;
    assign done   = (state_q == S_DONE);
    assign t1_en  = w_run && !stall && (g_q < C_G_N_IN);
    assign upd_en = w_run && !stall && (g_q >= C_G_DELAY) && (g_q < C_G_UPD_END);

    loop_nest_counter #(
        .UNROLL (UNROLL),
        .IMG_W  (IMG_W),
        .ROWS   (IMG_H),
        .YW     (YW)
    ) u_t1_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .adv    (t1_en),
        .x      (t1_x),
        .y      (t1_y),
        .last   (w_t1_last)
    );

    loop_nest_counter #(
        .UNROLL (UNROLL),
        .IMG_W  (IMG_W),
        .ROWS   (IMG_H - 2),
        .YW     (YW)
    ) u_upd_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .adv    (upd_en),
        .x      (upd_x),
        .y      (upd_y),
        .last   (w_upd_last)
    );

    // Frame end is tracked by g; the walkers' own last flags are spare
    assign w_unused_last = w_t1_last ^ w_upd_last;

`ifdef STENCIL_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle count: cleared on start acceptance, saturating, frozen outside RUN
    always_comb begin
        perf_d = perf_q;
        if ((state_q == S_IDLE) && start) begin
            perf_d = '0;
        end else if (w_run && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Performance counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule : stencil_unrolled_ctrl
`default_nettype wire

// File: tb/tb_stencil_unrolled_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stencil_unrolled_ctrl
// Description : Self-checking bench for stencil_unrolled_ctrl. A schedule
//               model counts completed iterations and derives every expected
//               strobe and coordinate arithmetically from that count.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stencil_unrolled_ctrl;

    localparam int UNROLL = 4;
    localparam int IMG_W  = 16;
    localparam int IMG_H  = 6;
    localparam int COLS   = IMG_W / UNROLL;
    localparam int DELAY  = 2 * COLS + 1;
    localparam int N_IN   = COLS * IMG_H;
    localparam int N_OUT  = COLS * (IMG_H - 2);
    localparam int LAST   = ((N_IN > DELAY + N_OUT) ? N_IN : DELAY + N_OUT) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stall;
    logic       busy;
    logic       done;
    logic       t1_en;
    logic [3:0] t1_x;
    logic [2:0] t1_y;
    logic       upd_en;
    logic [3:0] upd_x;
    logic [2:0] upd_y;
`ifdef STENCIL_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    stencil_unrolled_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .t1_en       (t1_en),
        .t1_x        (t1_x),
        .t1_y        (t1_y),
        .upd_en      (upd_en),
        .upd_x       (upd_x),
        .upd_y       (upd_y)
`ifdef STENCIL_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model: phase 0 idle, 1 running, 2 done; m_k = iterations completed
    int m_phase = 0;
    int m_k     = 0;
    int m_perf  = 0;

    // Observations within the current frame (cycle 0 = first run cycle)
    int fc        = 0;
    int done_at   = -1;
    int upd_last  = -1;
    int done_cnt  = 0;
    int t1_cnt    = 0;
    int upd_cnt   = 0;
    int perf_done = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int t1_issued();
        return (m_k < N_IN) ? m_k : N_IN;
    endfunction

    function automatic int upd_issued();
        if (m_k <= DELAY) return 0;
        return ((m_k - DELAY) < N_OUT) ? (m_k - DELAY) : N_OUT;
    endfunction

    // Compare every output against the iteration-count model
    task automatic check_outputs();
        logic run;
        int   n1;
        int   n2;
        run = (m_phase == 1);
        n1  = t1_issued();
        n2  = upd_issued();
        chk("busy",   32'(busy),   32'(run));
        chk("done",   32'(done),   32'(m_phase == 2));
        chk("t1_en",  32'(t1_en),  32'(run && !stall && (m_k < N_IN)));
        chk("upd_en", 32'(upd_en), 32'(run && !stall && (m_k >= DELAY) && (m_k < DELAY + N_OUT)));
        chk("t1_x",   32'(t1_x),   32'((n1 % COLS) * UNROLL));
        chk("t1_y",   32'(t1_y),   32'((n1 / COLS) % IMG_H));
        chk("upd_x",  32'(upd_x),  32'((n2 % COLS) * UNROLL));
        chk("upd_y",  32'(upd_y),  32'((n2 / COLS) % (IMG_H - 2)));
`ifdef STENCIL_CTRL_PERF_EN
        chk("perf",   perf_cycles, 32'(m_perf));
        if (done) perf_done = int'(perf_cycles);
`endif
        if (done) begin
            done_cnt++;
            done_at = fc;
        end
        if (upd_en) begin
            upd_last = fc;
            upd_cnt++;
        end
        if (t1_en) t1_cnt++;
    endtask

    // Apply the rules at a clock edge
    task automatic advance(input logic s, input logic st);
        case (m_phase)
            0: begin
                if (st) begin
                    m_phase  = 1;
                    m_k      = 0;
                    m_perf   = 0;
                    fc       = 0;
                    done_at  = -1;
                    upd_last = -1;
                end else begin
                    fc++;
                end
            end
            1: begin
                m_perf++;
                if (!s) begin
                    if (m_k == LAST) m_phase = 2;
                    m_k++;
                end
                fc++;
            end
            default: begin
                m_phase = 0;
                fc++;
            end
        endcase
    endtask

    // One clock cycle: drive just after the edge, check mid-cycle
    task automatic step(input logic s, input logic st);
        stall = s;
        start = st;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rst_n) advance(s, st);
        #1;
    endtask

    task automatic clear_stats();
        done_cnt  = 0;
        t1_cnt    = 0;
        upd_cnt   = 0;
        perf_done = -1;
    endtask

    // Assert reset mid-cycle and check outputs drop without a clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy",   32'(busy),   0);
        chk("rst_done",   32'(done),   0);
        chk("rst_t1_en",  32'(t1_en),  0);
        chk("rst_upd_en", 32'(upd_en), 0);
        chk("rst_coords", 32'({t1_x, t1_y, upd_x, upd_y}), 0);
        m_phase = 0;
        m_k     = 0;
        m_perf  = 0;
        repeat (2) step(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Nominal frame
        clear_stats();
        step(1'b0, 1'b1);
        for (int c = 0; c <= 26; c++) step(1'b0, 1'b0);
        chk("nom_done_cycle", 32'(done_at),  25);
        chk("nom_upd_last",   32'(upd_last), 24);
        chk("nom_t1_count",   32'(t1_cnt),   24);
        chk("nom_upd_count",  32'(upd_cnt),  16);
        chk("nom_done_count", 32'(done_cnt), 1);
`ifdef STENCIL_CTRL_PERF_EN
        chk("nom_perf_at_done", 32'(perf_done), 25);
`endif

        // Three stall cycles starting at cycle 10
        clear_stats();
        step(1'b0, 1'b1);
        for (int c = 0; c <= 29; c++) step(c >= 10 && c < 13, 1'b0);
        chk("stall_done_cycle", 32'(done_at),  28);
        chk("stall_upd_last",   32'(upd_last), 27);
        chk("stall_done_count", 32'(done_cnt), 1);
`ifdef STENCIL_CTRL_PERF_EN
        chk("stall_perf_at_done", 32'(perf_done), 28);
`endif

        // Start while busy (cycle 5) and during DONE (cycle 25) is ignored
        clear_stats();
        step(1'b0, 1'b1);
        for (int c = 0; c <= 25; c++) step(1'b0, c == 5 || c == 25);
        chk("busy_start_done_count", 32'(done_cnt), 1);
        chk("busy_start_done_cycle", 32'(done_at),  25);
        step(1'b0, 1'b1);
        for (int c = 0; c <= 26; c++) step(1'b0, 1'b0);
        chk("relaunch_done_cycle", 32'(done_at),  25);
        chk("relaunch_done_count", 32'(done_cnt), 2);

        // Reset in the middle of a frame, then a clean frame
        clear_stats();
        step(1'b0, 1'b1);
        for (int c = 0; c < 12; c++) step(1'b0, 1'b0);
        do_reset();
        chk("midrst_no_done", 32'(done_cnt), 0);
        step(1'b0, 1'b1);
        for (int c = 0; c <= 26; c++) step(1'b0, 1'b0);
        chk("postrst_done_cycle", 32'(done_at),  25);
        chk("postrst_upd_last",   32'(upd_last), 24);

        // Stall held over the final iteration
        clear_stats();
        step(1'b0, 1'b1);
        for (int c = 0; c <= 29; c++) step(c >= 24 && c < 27, 1'b0);
        chk("finstall_done_cycle", 32'(done_at),  28);
        chk("finstall_done_count", 32'(done_cnt), 1);

        // Random stall/start traffic
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_stencil_unrolled_ctrl
`default_nettype wire
